// File: rtl/sprite_path_pkg.sv
// Shared types and preset segment tables for the sprite path controller.
// Descriptor fields are sized for the widest supported configuration; each controller slices them.
package sprite_path_pkg;

  localparam int unsigned VEL_W = 48;  // covers POS_W+FRAC_BITS+1 up to 48 bits
  localparam int unsigned THR_W = 16;  // covers POS_W up to 16
  localparam int unsigned PH_W  = 8;   // covers PHOTO_W up to 8

  typedef enum logic {AX_X, AX_Y} axis_e;
  typedef enum logic {CMP_GE, CMP_LT} cmp_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef struct packed {
    logic signed [VEL_W-1:0] dx;
    logic signed [VEL_W-1:0] dy;
    axis_e                   axis;
    cmp_e                    cmp;
    logic [THR_W-1:0]        thresh;
    logic [31:0]             max_cycles;
    logic [PH_W-1:0]         photo_base;
    logic [PH_W-1:0]         photo_cnt;
  } seg_t;

  function automatic seg_t mk_seg(longint dx, longint dy, axis_e axis, cmp_e cmp,
                                  int unsigned thresh, int unsigned max_cycles,
                                  int unsigned photo_base, int unsigned photo_cnt);
    seg_t s;
    s            = '0;
    s.dx         = VEL_W'(dx);
    s.dy         = VEL_W'(dy);
    s.axis       = axis;
    s.cmp        = cmp;
    s.thresh     = THR_W'(thresh);
    s.max_cycles = max_cycles;
    s.photo_base = PH_W'(photo_base);
    s.photo_cnt  = PH_W'(photo_cnt);
    return s;
  endfunction

  // Velocities assume the default FRAC_BITS of 24 (one pixel = 1 << 24).
  localparam seg_t [0:3] DOG_INTRO = '{
    mk_seg(-(64'sd1 << 18), 0, AX_X, CMP_LT, 600, 0, 0, 3),              // walk
    mk_seg(0, 0, AX_X, CMP_LT, 0, 100_000_000, 3, 2),                    // spot
    mk_seg(-(64'sd1 << 18), -(64'sd1 << 19), AX_Y, CMP_LT, 400, 0, 5, 1), // jump
    mk_seg(0, (64'sd1 << 19), AX_Y, CMP_GE, 595, 0, 6, 1)                // fall
  };

  localparam seg_t [0:1] DUCK_FLY = '{
    mk_seg((64'sd1 << 19), -(64'sd1 << 19), AX_Y, CMP_LT, 100, 0, 7, 3),
    mk_seg(0, -(64'sd1 << 20), AX_Y, CMP_GE, 4000, 0, 10, 3)
  };

endpackage

// File: rtl/anim_frame_ctr.sv
// Frame divider plus a photo counter that wraps within [base, base+cnt).
// clear reloads the photo from base and restarts the divider phase.
module anim_frame_ctr #(
  parameter int unsigned PHOTO_W     = 4,
  parameter int unsigned FRAME_DIV   = 8_000_000,
  parameter int unsigned RESET_PHOTO = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               enable,
  input  logic [PHOTO_W-1:0] base,
  input  logic [PHOTO_W-1:0] cnt,
  output logic [PHOTO_W-1:0] photo_index
);

  localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic [DIV_W-1:0]   div_q, div_d;
  logic [PHOTO_W-1:0] photo_q, photo_d;
  logic [PHOTO_W-1:0] offs;
  logic [PHOTO_W:0]   offs_inc;
  logic [PHOTO_W-1:0] photo_step;
  logic               div_last;

  always_comb begin
    offs       = photo_q - base;
    offs_inc   = {1'b0, offs} + {{PHOTO_W{1'b0}}, 1'b1};
    photo_step = (offs_inc >= {1'b0, cnt}) ? base : base + offs_inc[PHOTO_W-1:0];
    div_last   = (div_q == DIV_W'(FRAME_DIV - 1));

    div_d   = div_q;
    photo_d = photo_q;
    if (clear) begin
      div_d   = '0;
      photo_d = base;
    end else if (enable) begin
      if (div_last) begin
        div_d   = '0;
        photo_d = photo_step;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q   <= '0;
      photo_q <= PHOTO_W'(RESET_PHOTO);
    end else begin
      div_q   <= div_d;
      photo_q <= photo_d;
    end
  end

  assign photo_index = photo_q;

endmodule

// File: rtl/sprite_path_ctl.sv
// Drives one sprite through a parameter table of motion segments with per-segment
// velocity, end condition and animation strip. All outputs come straight from flops.
module sprite_path_ctl
  import sprite_path_pkg::*;
#(
  parameter int unsigned POS_W      = 12,
  parameter int unsigned FRAC_BITS  = 24,
  parameter int unsigned PHOTO_W    = 4,
  parameter int unsigned N_SEG      = 4,
  parameter int unsigned FRAME_DIV  = 8_000_000,
  parameter int unsigned HOME_X     = 1024,
  parameter int unsigned HOME_Y     = 595,
  parameter int unsigned HOME_PHOTO = 0,
  parameter seg_t [0:N_SEG-1] SEG_TABLE = DOG_INTRO,
  localparam int unsigned SEG_W = (N_SEG > 1) ? $clog2(N_SEG) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pause,
  input  logic               abort,
  output logic [POS_W-1:0]   xpos,
  output logic [POS_W-1:0]   ypos,
  output logic [PHOTO_W-1:0] photo_index,
  output logic [SEG_W-1:0]   seg_idx,
  output logic               busy,
  output logic               done
);

  localparam int unsigned ACC_W = POS_W + FRAC_BITS;
  localparam logic [ACC_W-1:0] HOME_XA = ACC_W'(HOME_X) << FRAC_BITS;
  localparam logic [ACC_W-1:0] HOME_YA = ACC_W'(HOME_Y) << FRAC_BITS;

  state_e             state_q, state_d;
  logic [SEG_W-1:0]   seg_q, seg_d, seg_nxt;
  logic [ACC_W-1:0]   xacc_q, xacc_d, yacc_q, yacc_d;
  logic [31:0]        cyc_q, cyc_d;
  logic               busy_q, done_q;
  logic               seg_last, cond_hit, timeout, end_hit;
  logic [POS_W-1:0]   axis_val, thr;
  logic [31:0]        max_cyc;
  logic               ctr_clear, ctr_enable;
  logic [PHOTO_W-1:0] ctr_base, ctr_cnt;

  assign xpos    = xacc_q[ACC_W-1:FRAC_BITS];
  assign ypos    = yacc_q[ACC_W-1:FRAC_BITS];
  assign seg_idx = seg_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // End condition uses the registered position, so it is checked before this cycle's motion.
  always_comb begin
    seg_last = (seg_q == SEG_W'(N_SEG - 1));
    seg_nxt  = seg_last ? '0 : seg_q + SEG_W'(1);
    axis_val = (SEG_TABLE[seg_q].axis == AX_X) ? xpos : ypos;
    thr      = SEG_TABLE[seg_q].thresh[POS_W-1:0];
    max_cyc  = SEG_TABLE[seg_q].max_cycles;
    cond_hit = (SEG_TABLE[seg_q].cmp == CMP_GE) ? (axis_val >= thr) : (axis_val < thr);
    timeout  = (max_cyc != 32'd0) && (cyc_q == max_cyc - 32'd1);
    end_hit  = cond_hit || timeout;
    ctr_cnt  = SEG_TABLE[seg_q].photo_cnt[PHOTO_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    xacc_d     = xacc_q;
    yacc_d     = yacc_q;
    cyc_d      = cyc_q;
    ctr_clear  = 1'b0;
    ctr_enable = 1'b0;
    ctr_base   = SEG_TABLE[seg_q].photo_base[PHOTO_W-1:0];

    if (abort) begin
      state_d   = IDLE;
      seg_d     = '0;
      xacc_d    = HOME_XA;
      yacc_d    = HOME_YA;
      cyc_d     = '0;
      ctr_clear = 1'b1;
      ctr_base  = PHOTO_W'(HOME_PHOTO);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = RUN;
            seg_d     = '0;
            cyc_d     = '0;
            ctr_clear = 1'b1;
            ctr_base  = SEG_TABLE[0].photo_base[PHOTO_W-1:0];
          end
        end
        RUN: begin
          if (!pause) begin
            if (end_hit && seg_last) begin
              // Home is loaded on entry to DONE so the pulse cycle already shows it.
              state_d   = DONE;
              seg_d     = '0;
              xacc_d    = HOME_XA;
              yacc_d    = HOME_YA;
              cyc_d     = '0;
              ctr_clear = 1'b1;
              ctr_base  = PHOTO_W'(HOME_PHOTO);
            end else if (end_hit) begin
              seg_d     = seg_nxt;
              cyc_d     = '0;
              ctr_clear = 1'b1;
              ctr_base  = SEG_TABLE[seg_nxt].photo_base[PHOTO_W-1:0];
            end else begin
              // Wraps modulo 2^ACC_W: the low ACC_W bits of the sign-extended velocity.
              xacc_d     = xacc_q + SEG_TABLE[seg_q].dx[ACC_W-1:0];
              yacc_d     = yacc_q + SEG_TABLE[seg_q].dy[ACC_W-1:0];
              cyc_d      = cyc_q + 32'd1;
              ctr_enable = 1'b1;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      seg_q   <= '0;
      xacc_q  <= HOME_XA;
      yacc_q  <= HOME_YA;
      cyc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      xacc_q  <= xacc_d;
      yacc_q  <= yacc_d;
      cyc_q   <= cyc_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  anim_frame_ctr #(
    .PHOTO_W     (PHOTO_W),
    .FRAME_DIV   (FRAME_DIV),
    .RESET_PHOTO (HOME_PHOTO)
  ) u_anim (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (ctr_clear),
    .enable      (ctr_enable),
    .base        (ctr_base),
    .cnt         (ctr_cnt),
    .photo_index (photo_index)
  );

endmodule

// File: tb/tb_sprite_path_ctl.sv
// Scoreboard bench for sprite_path_ctl: the driver queues hand-derived per-cycle
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_sprite_path_ctl;
  import sprite_path_pkg::*;

  // 1 px = 16 with FRAC_BITS=4; home (100,50).
  localparam seg_t [0:5] TB_TABLE = '{
    mk_seg(-16, 0, AX_X, CMP_LT, 90, 0, 2, 3),     // walk 100 -> 89
    mk_seg(0, 0, AX_X, CMP_LT, 0, 5, 5, 1),        // timeout after 5 cycles
    mk_seg(0, 32, AX_Y, CMP_GE, 60, 0, 7, 2),      // y 50 -> 60, 2 px/clk
    mk_seg(-1424, 0, AX_X, CMP_LT, 1, 0, 1, 1),    // x 89 -> 0 in one step
    mk_seg(-16, 0, AX_X, CMP_GE, 4000, 0, 0, 1),   // x 0 -> 4095 wrap
    mk_seg(0, 0, AX_Y, CMP_GE, 0, 0, 9, 1)         // true on entry, last
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, start = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [11:0] xpos, ypos;
  logic [3:0]  photo_index;
  logic [2:0]  seg_idx;
  logic        busy, done;

  sprite_path_ctl #(
    .POS_W      (12),
    .FRAC_BITS  (4),
    .PHOTO_W    (4),
    .N_SEG      (6),
    .FRAME_DIV  (3),
    .HOME_X     (100),
    .HOME_Y     (50),
    .HOME_PHOTO (0),
    .SEG_TABLE  (TB_TABLE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pause       (pause),
    .abort       (abort),
    .xpos        (xpos),
    .ypos        (ypos),
    .photo_index (photo_index),
    .seg_idx     (seg_idx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [3:0]  ph;
    logic [2:0]  seg;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t  sb_q[$];
  string name_q[$];
  exp_t  tr[$];
  exp_t  ptr[$];
  exp_t  home_row;
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic exp_t row(int x, int y, int ph, int seg, logic b, logic d);
    exp_t e;
    e.x = 12'(x); e.y = 12'(y); e.ph = 4'(ph); e.seg = 3'(seg); e.busy = b; e.done = d;
    return e;
  endfunction

  // Outputs after each clock edge of one full run; index 0 is the edge that samples start.
  task automatic build_trace();
    tr.delete();
    tr.push_back(row(100, 50, 2, 0, 1, 0));
    for (int m = 1; m <= 11; m++) tr.push_back(row(100 - m, 50, 2 + (m / 3) % 3, 0, 1, 0));
    for (int k = 0; k < 5; k++) tr.push_back(row(89, 50, 5, 1, 1, 0));
    tr.push_back(row(89, 50, 7, 2, 1, 0));
    for (int m = 1; m <= 5; m++) tr.push_back(row(89, 50 + 2 * m, 7 + (m / 3) % 2, 2, 1, 0));
    tr.push_back(row(89, 60, 1, 3, 1, 0));
    tr.push_back(row(0, 60, 1, 3, 1, 0));
    tr.push_back(row(0, 60, 0, 4, 1, 0));
    tr.push_back(row(4095, 60, 0, 4, 1, 0));
    tr.push_back(row(4095, 60, 9, 5, 1, 0));
    tr.push_back(row(100, 50, 0, 0, 0, 1));
    tr.push_back(row(100, 50, 0, 0, 0, 0));
  endtask

  task automatic step(input logic st, input logic pa, input logic ab, input logic rs,
                      input exp_t e, input string name);
    start = st; pause = pa; abort = ab; rst_n = rs;
    @(posedge clk);
    #1;
    sb_q.push_back(e);
    name_q.push_back(name);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t  e;
      exp_t  act;
      string nm;
      e   = sb_q.pop_front();
      nm  = name_q.pop_front();
      act = {xpos, ypos, photo_index, seg_idx, busy, done};
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL %s @%0t: got x=%0d y=%0d ph=%0d seg=%0d busy=%b done=%b, need x=%0d y=%0d ph=%0d seg=%0d busy=%b done=%b",
                 nm, $time, act.x, act.y, act.ph, act.seg, act.busy, act.done,
                 e.x, e.y, e.ph, e.seg, e.busy, e.done);
      end
    end
  end

  initial begin
    home_row = row(100, 50, 0, 0, 0, 0);
    build_trace();

    step(0, 0, 0, 0, home_row, "reset");
    step(0, 0, 0, 0, home_row, "reset");
    step(0, 0, 0, 1, home_row, "idle");
    step(0, 0, 0, 1, home_row, "idle");

    // Full run: walk, animation wrap, timeout, wrap below zero, done pulse.
    for (int i = 0; i < tr.size(); i++) step(i == 0, 0, 0, 1, tr[i], "run");
    step(0, 0, 0, 1, home_row, "idle_after_run");

    // Pause for 4 edges mid-walk (divider phase 1): outputs freeze, run ends 4 later.
    ptr.delete();
    for (int i = 0; i <= 4; i++) ptr.push_back(tr[i]);
    for (int i = 0; i < 4; i++) ptr.push_back(tr[4]);
    for (int i = 5; i < tr.size(); i++) ptr.push_back(tr[i]);
    for (int i = 0; i < ptr.size(); i++) step(i == 0, (i >= 5) && (i <= 8), 0, 1, ptr[i], "pause");

    // Abort while in segment 2: home next cycle, no done.
    for (int i = 0; i <= 18; i++) step(i == 0, 0, 0, 1, tr[i], "abort_pre");
    step(0, 0, 1, 1, home_row, "abort");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, home_row, "abort_after");

    // start and abort together in IDLE stay in IDLE.
    step(1, 0, 1, 1, home_row, "start_abort");
    step(0, 0, 0, 1, home_row, "start_abort_idle");

    // Reset mid-run beats pause and abort.
    for (int i = 0; i <= 14; i++) step(i == 0, 0, 0, 1, tr[i], "reset_pre");
    step(0, 1, 1, 0, home_row, "reset_mid");
    step(0, 0, 0, 1, home_row, "reset_after");

    // start held through DONE: new run begins two cycles after done.
    for (int i = 0; i < tr.size(); i++) step(1, 0, 0, 1, tr[i], "held");
    step(1, 0, 0, 1, tr[0], "held_restart");
    step(0, 0, 0, 1, tr[1], "held_move");
    step(0, 0, 1, 1, home_row, "held_abort");

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, need 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_path_ctl.md
# sprite_path_ctl

Parametrised successor to the fixed dog controller: it drives one sprite through a table of motion segments. Each segment has a signed fixed-point velocity, an end condition and an animation strip. Segments are selected from a parameter table, so one RTL serves the dog, the ducks and future sprites. It sits between game logic (start/pause/abort) and the draw pipeline (xpos/ypos/photo_index). All outputs are registered.

## Interface
- POS_W, 12: integer pixel width of xpos/ypos.
- FRAC_BITS, 24: fractional bits of the internal position accumulators. Accumulator width is POS_W+FRAC_BITS.
- PHOTO_W, 4: photo_index width.
- N_SEG, 4: number of segments, 1..8. SEG_W = max(1, $clog2(N_SEG)).
- FRAME_DIV, 8_000_000: cycles per animation frame step, ≥1.
- HOME_X, 1024 / HOME_Y, 595 / HOME_PHOTO, 0: idle position and idle photo.
- SEG_TABLE, seg_t [N_SEG]: per-segment descriptor, defined in the package.
- clk  in  1  system clock. One clock; reset is synchronous and active-low.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  level-sampled request; accepted only in IDLE.
- pause  in  1  freezes all state while high.
- abort  in  1  returns to IDLE/home on the next cycle; no done pulse.
- xpos, ypos  out  POS_W  integer part of the accumulators.
- photo_index  out  PHOTO_W  sprite frame to draw.
- seg_idx  out  SEG_W  active segment.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on normal completion.

## Operation
- seg_t fields:
  - dx, dy: signed POS_W+FRAC_BITS+1 bits, applied per clock.
  - axis: X or Y.
  - cmp: GE or LT.
  - thresh: POS_W unsigned.
  - max_cycles: 32-bit; 0 means no timeout.
  - photo_base, photo_cnt: PHOTO_W each; photo_cnt ≥ 1.
- States:
  - IDLE: position = home, photo = HOME_PHOTO, seg_idx = 0, busy = 0.
  - RUN.
  - DONE: lasts one cycle, done = 1, busy = 0, position and photo already at home. Always goes to IDLE next.
- IDLE→RUN on start && !abort. On entry: seg_idx = 0, divider = 0, segment cycle counter = 0, photo = SEG_TABLE[0].photo_base.
- RUN, non-paused cycle:
  - End condition: (axis value cmp thresh), evaluated on the current registered integer position. OR (max_cycles ≠ 0 && seg_cyc == max_cycles−1).
  - If the end condition is true: position is unchanged.
    - Not the last segment: seg_idx+1, divider and seg_cyc cleared, photo = new photo_base.
    - Last segment: go to DONE.
  - Otherwise: acc += sign-extended velocity, truncated to POS_W+FRAC_BITS bits, so the position wraps modulo 2^(POS_W+FRAC_BITS). Then seg_cyc+1 and divider+1.
    - When the divider reaches FRAME_DIV−1: divider clears and photo steps.
    - Photo stepping: photo = base + ((photo−base+1) mod photo_cnt).
- pause=1 in RUN: every register holds, including the divider and seg_cyc.
- abort=1 in any state: next cycle is IDLE, all outputs at home/reset values, done stays 0.
- Priority: abort > pause > start/motion.
- start is ignored in RUN and DONE. If start is held through DONE, a new run begins 2 cycles after done (DONE→IDLE→RUN).

## Timing
- Reset values (rst_n=0 at a clock edge):
  - xpos = HOME_X, ypos = HOME_Y, photo_index = HOME_PHOTO.
  - seg_idx = 0, busy = 0, done = 0, state IDLE.
- Latency from start to busy is 1 cycle. The first position change is visible 2 cycles after start, provided the segment-0 condition is false at home.
- The end condition is checked before motion. A segment whose condition is already true on entry lasts exactly 1 cycle and moves nothing.
- done rises 1 cycle after the final end-condition cycle and lasts exactly 1 cycle.
- Reset asserted mid-run takes priority over abort and pause. All outputs equal their reset values on the following cycle.

## Structure
- Package sprite_path_pkg:
  - seg_t struct.
  - axis_e {AX_X, AX_Y}.
  - cmp_e {CMP_GE, CMP_LT}.
  - state_e {IDLE, RUN, DONE}.
  - Preset SEG_TABLE constants: DOG_INTRO (walk, spot, jump, fall) and DUCK_FLY.
- Sub-module anim_frame_ctr:
  - Contents: divider plus wrapping photo counter.
  - Inputs: clk, rst_n, clear, enable, base, cnt.
  - Output: photo_index.

## Test plan
- Walk-to-threshold:
  - Setup: FRAC_BITS=4, HOME_X=100, seg0 dx=−16, X LT 90, then a last segment whose condition is true on entry.
  - Stimulus: start for 1 cycle.
  - Required response: xpos goes 100→89 over 11 cycles, seg_idx goes to 1, done pulses exactly once, then xpos = 100.
- Animation wrap:
  - Setup: FRAME_DIV=3, photo_base=2, photo_cnt=3, long segment.
  - Required response: photo sequence 2,2,2,3,3,3,4,4,4,2, with one step per 3 moving cycles.
- Timeout:
  - Setup: dx=dy=0, max_cycles=5.
  - Required response: the segment advances after exactly 5 RUN cycles.
- Pause:
  - Stimulus: hold pause for 4 cycles mid-segment.
  - Required response: xpos, photo_index, seg_idx and the divider phase are frozen for 4 cycles, and completion is delayed by exactly 4 cycles.
- Abort and start conflicts:
  - Stimulus: abort in segment 2.
  - Required response: next cycle xpos/ypos = HOME_X/HOME_Y, busy = 0, no done pulse.
  - Stimulus: start and abort in the same IDLE cycle.
  - Required response: the block stays in IDLE.
- Wrap and reset:
  - Stimulus: dx negative from x=0.
  - Required response: xpos = 4095 after 1 pixel of movement.
  - Stimulus: rst_n=0 mid-run.
  - Required response: all outputs at reset values next cycle.
